// File: rtl/mips_rf_pkg.sv
// Shared types and defaults for the MIPS register-file port controller.
// Optional bypass feature is selected with the MIPS_RF_BYPASS_EN macro.
package mips_rf_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_REG   = 0;
  localparam int NUM_LANES  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;
endpackage

// File: rtl/rf_operand_lane.sv
// One operand lane: latched index/enable, zero-force, optional writeback bypass
// (MIPS_RF_BYPASS_EN) and the holding register presented downstream.
module rf_operand_lane import mips_rf_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              latch_i,
  input  logic [ADDR_W-1:0] idx_i,
  input  logic              en_i,
  input  logic              st_read_i,
  input  logic              st_wait_i,
  input  logic              wb_valid_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic [DATA_W-1:0] rf_data_i,
  output logic              rf_en_o,
  output logic [ADDR_W:0]   rf_addr_o,
  output logic [DATA_W-1:0] hold_o
);
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              en_q, en_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              live;

  // A disabled lane or $zero never touches the register file.
  assign live      = en_q && (idx_q != ADDR_W'(ZERO_REG));
  assign rf_en_o   = st_read_i && live;
  assign rf_addr_o = {1'b0, idx_q};
  assign hold_o    = hold_q;

  always_comb begin
    idx_d = idx_q;
    en_d  = en_q;
    if (latch_i) begin
      idx_d = idx_i;
      en_d  = en_i;
    end
  end

`ifdef MIPS_RF_BYPASS_EN
  logic              hit;
  logic              byp_vld_q, byp_vld_d;
  logic [DATA_W-1:0] byp_data_q, byp_data_d;

  assign hit = live && wb_valid_i && (wb_addr_i == idx_q);

  // READ-cycle hit is parked; a WAIT-cycle hit is newer and takes priority.
  always_comb begin
    byp_vld_d  = byp_vld_q;
    byp_data_d = byp_data_q;
    hold_d     = hold_q;
    if (st_read_i) begin
      byp_vld_d  = hit;
      byp_data_d = wb_data_i;
    end
    if (st_wait_i) begin
      if (!live)          hold_d = '0;
      else if (hit)       hold_d = wb_data_i;
      else if (byp_vld_q) hold_d = byp_data_q;
      else                hold_d = rf_data_i;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      byp_vld_q  <= 1'b0;
      byp_data_q <= '0;
    end else begin
      byp_vld_q  <= byp_vld_d;
      byp_data_q <= byp_data_d;
    end
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wb_valid_i, wb_addr_i, wb_data_i};

  always_comb begin
    hold_d = hold_q;
    if (st_wait_i) hold_d = live ? rf_data_i : '0;
  end
`endif

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      idx_q  <= '0;
      en_q   <= 1'b0;
      hold_q <= '0;
    end else begin
      idx_q  <= idx_d;
      en_q   <= en_d;
      hold_q <= hold_d;
    end
  end
endmodule

// File: rtl/mips_rf_port_ctrl.sv
// Decode-side register-file port controller: two registered read channels,
// pass-through write channel, valid/ready operand response. Bypass: MIPS_RF_BYPASS_EN.
module mips_rf_port_ctrl import mips_rf_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_rs,
  input  logic [ADDR_W-1:0] req_rt,
  input  logic              req_rs_en,
  input  logic              req_rt_en,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rs_data,
  output logic [DATA_W-1:0] rsp_rt_data,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              rf_r_1_en,
  output logic              rf_r_2_en,
  output logic [ADDR_W:0]   rf_addr_r_1,
  output logic [ADDR_W:0]   rf_addr_r_2,
  input  logic [DATA_W-1:0] rf_r_data_1,
  input  logic [DATA_W-1:0] rf_r_data_2,
  output logic              rf_w_en,
  output logic [ADDR_W:0]   rf_addr_w,
  output logic [DATA_W-1:0] rf_w_data
);
  state_e state_q, state_d;
  logic   accept;

  logic [NUM_LANES-1:0][ADDR_W-1:0] lane_idx;
  logic [NUM_LANES-1:0]             lane_en;
  logic [NUM_LANES-1:0][DATA_W-1:0] lane_rf_data;
  logic [NUM_LANES-1:0]             lane_rf_en;
  logic [NUM_LANES-1:0][ADDR_W:0]   lane_rf_addr;
  logic [NUM_LANES-1:0][DATA_W-1:0] lane_hold;

  assign req_ready = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == ST_RESP);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_READ;
      ST_READ: state_d = ST_WAIT;
      ST_WAIT: state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = accept ? ST_READ : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Lane 0 carries rs on read channel 1, lane 1 carries rt on channel 2.
  assign lane_idx     = {req_rt, req_rs};
  assign lane_en      = {req_rt_en, req_rs_en};
  assign lane_rf_data = {rf_r_data_2, rf_r_data_1};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    rf_operand_lane #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_lane (
      .clk       (clk),
      .arst_n    (arst_n),
      .latch_i   (accept),
      .idx_i     (lane_idx[l]),
      .en_i      (lane_en[l]),
      .st_read_i (state_q == ST_READ),
      .st_wait_i (state_q == ST_WAIT),
      .wb_valid_i(wb_valid),
      .wb_addr_i (wb_addr),
      .wb_data_i (wb_data),
      .rf_data_i (lane_rf_data[l]),
      .rf_en_o   (lane_rf_en[l]),
      .rf_addr_o (lane_rf_addr[l]),
      .hold_o    (lane_hold[l])
    );
  end

  assign rf_r_1_en   = lane_rf_en[0];
  assign rf_r_2_en   = lane_rf_en[1];
  assign rf_addr_r_1 = lane_rf_addr[0];
  assign rf_addr_r_2 = lane_rf_addr[1];
  assign rsp_rs_data = lane_hold[0];
  assign rsp_rt_data = lane_hold[1];

  // Writes to $zero are dropped here so the register file never sees them.
  assign rf_w_en   = wb_valid && (wb_addr != ADDR_W'(ZERO_REG));
  assign rf_addr_w = {1'b0, wb_addr};
  assign rf_w_data = wb_data;
endmodule

// File: tb/tb_mips_rf_port_ctrl.sv
// Self-checking bench for mips_rf_port_ctrl with a registered register-file model
// and an architectural register model for expected operands.
module tb_mips_rf_port_ctrl;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          req_valid = 1'b0, req_ready;
  logic [AW-1:0] req_rs = '0, req_rt = '0;
  logic          req_rs_en = 1'b0, req_rt_en = 1'b0;
  logic          rsp_valid, rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rs_data, rsp_rt_data;
  logic          wb_valid = 1'b0;
  logic [AW-1:0] wb_addr = '0;
  logic [DW-1:0] wb_data = '0;
  logic          rf_r_1_en, rf_r_2_en, rf_w_en;
  logic [AW:0]   rf_addr_r_1, rf_addr_r_2, rf_addr_w;
  logic [DW-1:0] rf_r_data_1, rf_r_data_2, rf_w_data;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [DW-1:0] mem  [0:63];
  logic [DW-1:0] arch [0:31];

  always #5 clk = ~clk;

  mips_rf_port_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .arst_n(arst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs(req_rs), .req_rt(req_rt), .req_rs_en(req_rs_en), .req_rt_en(req_rt_en),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rs_data(rsp_rs_data), .rsp_rt_data(rsp_rt_data),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_r_1_en(rf_r_1_en), .rf_r_2_en(rf_r_2_en),
    .rf_addr_r_1(rf_addr_r_1), .rf_addr_r_2(rf_addr_r_2),
    .rf_r_data_1(rf_r_data_1), .rf_r_data_2(rf_r_data_2),
    .rf_w_en(rf_w_en), .rf_addr_w(rf_addr_w), .rf_w_data(rf_w_data)
  );

  // Register file (read-old on same-edge write) driven by the DUT, plus the
  // architectural model driven by the writeback inputs themselves.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rf_w_en)   mem[rf_addr_w] <= rf_w_data;
    if (rf_r_1_en) rf_r_data_1 <= mem[rf_addr_r_1];
    if (rf_r_2_en) rf_r_data_2 <= mem[rf_addr_r_2];
    if (wb_valid && wb_addr != '0) arch[wb_addr] <= wb_data;
  end

  function automatic logic [DW-1:0] model_val(input logic [AW-1:0] idx, input logic en);
    return (en && idx != '0) ? arch[idx] : '0;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_req(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                           input logic rse, input logic rte);
    req_valid = 1'b1; req_rs = rs; req_rt = rt; req_rs_en = rse; req_rt_en = rte;
  endtask

  task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_valid = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic rand_wb(input logic [AW-1:0] a, input logic [AW-1:0] b);
    int sel;
    sel = $urandom_range(0, 3);
    wb_valid = ($urandom_range(0, 2) != 0);
    wb_addr  = (sel == 0) ? a : (sel == 1) ? b : AW'($urandom_range(0, 31));
    wb_data  = $urandom;
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEAD_BEEF;
    #2;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %0b exp 0", rsp_valid); end
    tests++; if (rsp_rs_data !== '0 || rsp_rt_data !== '0) begin fails++; $display("FAIL reset_rsp_data got %h/%h exp 0/0", rsp_rs_data, rsp_rt_data); end
    tests++; if (rf_r_1_en !== 1'b0 || rf_r_2_en !== 1'b0) begin fails++; $display("FAIL reset_rf_r_en got %0b%0b exp 00", rf_r_1_en, rf_r_2_en); end
    tests++; if (rf_addr_r_1 !== '0 || rf_addr_r_2 !== '0) begin fails++; $display("FAIL reset_rf_addr got %0d/%0d exp 0/0", rf_addr_r_1, rf_addr_r_2); end
    tests++; if (rf_w_en !== 1'b1 || rf_addr_w !== 6'd3 || rf_w_data !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL reset_wb_pass got en=%0b a=%0d d=%h exp 1/3/deadbeef", rf_w_en, rf_addr_w, rf_w_data); end
    tick(); tick();
    wb_valid = 1'b0;
    arst_n = 1'b1;
    tick();
    tests++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_release got rdy=%0b vld=%0b exp 1/0", req_ready, rsp_valid); end
  endtask

  task automatic test_basic();
    write_reg(5'd5, 32'h1234_5678);
    start_req(5'd5, 5'd0, 1'b1, 1'b1);
    #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL basic_req_ready got %0b exp 1", req_ready); end
    tick(); req_valid = 1'b0; #1;
    tests++; if (rf_r_1_en !== 1'b1 || rf_addr_r_1 !== 6'd5 || rf_r_2_en !== 1'b0) begin
      fails++; $display("FAIL basic_read got en1=%0b a1=%0d en2=%0b exp 1/5/0", rf_r_1_en, rf_addr_r_1, rf_r_2_en); end
    tick();
    tests++; if (rsp_valid !== 1'b0 || rf_r_1_en !== 1'b0) begin fails++; $display("FAIL basic_wait got vld=%0b en1=%0b exp 0/0", rsp_valid, rf_r_1_en); end
    tick();
    tests++; if (rsp_valid !== 1'b1 || rsp_rs_data !== 32'h1234_5678 || rsp_rt_data !== '0) begin
      fails++; $display("FAIL basic_rsp got vld=%0b rs=%h rt=%h exp 1/12345678/0", rsp_valid, rsp_rs_data, rsp_rt_data); end
    tick();
    tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL basic_done got vld=%0b rdy=%0b exp 0/1", rsp_valid, req_ready); end
  endtask

  task automatic test_zero();
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF; #1;
    tests++; if (rf_w_en !== 1'b0) begin fails++; $display("FAIL zero_wb_drop got %0b exp 0", rf_w_en); end
    tick(); wb_valid = 1'b0;
    start_req(5'd0, 5'd5, 1'b1, 1'b0);
    tick(); req_valid = 1'b0; #1;
    tests++; if (rf_r_1_en !== 1'b0 || rf_r_2_en !== 1'b0) begin fails++; $display("FAIL zero_read_en got %0b%0b exp 00", rf_r_1_en, rf_r_2_en); end
    tick(); tick();
    tests++; if (rsp_valid !== 1'b1 || rsp_rs_data !== '0 || rsp_rt_data !== '0) begin
      fails++; $display("FAIL zero_rsp got vld=%0b rs=%h rt=%h exp 1/0/0", rsp_valid, rsp_rs_data, rsp_rt_data); end
    tick();
  endtask

  task automatic test_bypass();
    logic [DW-1:0] exp;
`ifdef MIPS_RF_BYPASS_EN
    exp = 32'hB;
`else
    exp = 32'h1;
`endif
    write_reg(5'd7, 32'h1);
    start_req(5'd7, 5'd7, 1'b1, 1'b1);
    tick(); req_valid = 1'b0;
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'hA;
    tick();
    wb_data = 32'hB;
    tick();
    wb_valid = 1'b0;
    tests++; if (rsp_valid !== 1'b1 || rsp_rs_data !== exp || rsp_rt_data !== exp) begin
      fails++; $display("FAIL bypass_rsp got vld=%0b rs=%h rt=%h exp 1/%h/%h", rsp_valid, rsp_rs_data, rsp_rt_data, exp, exp); end
    tick();
  endtask

  task automatic test_stall();
    logic [DW-1:0] exp_rs, exp_rt;
    rsp_ready = 1'b0;
    start_req(5'd7, 5'd5, 1'b1, 1'b1);
    tick(); req_valid = 1'b0;
    exp_rs = model_val(5'd7, 1'b1);
    exp_rt = model_val(5'd5, 1'b1);
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      wb_valid = (i == 0); wb_addr = 5'd7; wb_data = 32'hC; #1;
      tests++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rs_data !== exp_rs || rsp_rt_data !== exp_rt) begin
        fails++; $display("FAIL stall_hold[%0d] got vld=%0b rdy=%0b rs=%h rt=%h exp 1/0/%h/%h", i, rsp_valid, req_ready, rsp_rs_data, rsp_rt_data, exp_rs, exp_rt); end
      tick();
    end
    wb_valid = 1'b0; rsp_ready = 1'b1; #1;
    tests++; if (rsp_rs_data !== exp_rs || req_ready !== 1'b1) begin fails++; $display("FAIL stall_release got rs=%h rdy=%0b exp %h/1", rsp_rs_data, req_ready, exp_rs); end
    tick();
  endtask

  task automatic test_back_to_back();
    int t1;
    logic [DW-1:0] exp_a, exp_b;
    rsp_ready = 1'b1;
    start_req(5'd5, 5'd7, 1'b1, 1'b1);
    tick(); req_valid = 1'b0;
    exp_a = model_val(5'd5, 1'b1);
    exp_b = model_val(5'd7, 1'b1);
    tick(); tick();
    t1 = cyc;
    tests++; if (rsp_valid !== 1'b1 || rsp_rs_data !== exp_a || rsp_rt_data !== exp_b) begin
      fails++; $display("FAIL b2b_first got vld=%0b rs=%h rt=%h exp 1/%h/%h", rsp_valid, rsp_rs_data, rsp_rt_data, exp_a, exp_b); end
    start_req(5'd7, 5'd5, 1'b1, 1'b1); #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL b2b_accept got %0b exp 1", req_ready); end
    tick(); req_valid = 1'b0; #1;
    tests++; if (rsp_valid !== 1'b0 || rf_r_1_en !== 1'b1 || rf_addr_r_1 !== 6'd7) begin
      fails++; $display("FAIL b2b_read got vld=%0b en1=%0b a1=%0d exp 0/1/7", rsp_valid, rf_r_1_en, rf_addr_r_1); end
    tick(); tick();
    tests++; if (rsp_valid !== 1'b1 || (cyc - t1) != 3 || rsp_rs_data !== exp_b || rsp_rt_data !== exp_a) begin
      fails++; $display("FAIL b2b_second got vld=%0b gap=%0d rs=%h rt=%h exp 1/3/%h/%h", rsp_valid, cyc - t1, rsp_rs_data, rsp_rt_data, exp_b, exp_a); end
    tick();
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b1;
    start_req(5'd5, 5'd7, 1'b1, 1'b1);
    tick(); req_valid = 1'b0;
    tick();
    arst_n = 1'b0; #1;
    tests++; if (rsp_valid !== 1'b0 || rf_r_1_en !== 1'b0 || rf_r_2_en !== 1'b0) begin
      fails++; $display("FAIL midrst_drop got vld=%0b en=%0b%0b exp 0/00", rsp_valid, rf_r_1_en, rf_r_2_en); end
    tick();
    arst_n = 1'b1; #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL midrst_ready got %0b exp 1", req_ready); end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL midrst_novalid[%0d] got %0b exp 0", i, rsp_valid); end
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] rs, rt;
    logic          rse, rte;
    logic [DW-1:0] s0_rs, s0_rt, s2_rs, s2_rt, exp_rs, exp_rt;
    int            stall;
    for (int n = 0; n < 40; n++) begin
      rs = AW'($urandom_range(0, 31)); rt = AW'($urandom_range(0, 31));
      rse = ($urandom_range(0, 3) != 0); rte = ($urandom_range(0, 3) != 0);
      rsp_ready = 1'b1;
      start_req(rs, rt, rse, rte);
      rand_wb(rs, rt); #1;
      tests++; if (req_ready !== 1'b1 || rf_w_en !== (wb_valid && wb_addr != '0)) begin
        fails++; $display("FAIL rand_idle[%0d] got rdy=%0b wen=%0b", n, req_ready, rf_w_en); end
      tick(); req_valid = 1'b0;
      s0_rs = model_val(rs, rse); s0_rt = model_val(rt, rte);
      rand_wb(rs, rt); #1;
      tests++; if (rf_r_1_en !== (rse && rs != '0) || rf_r_2_en !== (rte && rt != '0)) begin
        fails++; $display("FAIL rand_read_en[%0d] got %0b%0b exp %0b%0b", n, rf_r_1_en, rf_r_2_en, rse && rs != '0, rte && rt != '0); end
      tick();
      rand_wb(rs, rt);
      tick();
      s2_rs = model_val(rs, rse); s2_rt = model_val(rt, rte);
`ifdef MIPS_RF_BYPASS_EN
      exp_rs = s2_rs; exp_rt = s2_rt;
`else
      exp_rs = s0_rs; exp_rt = s0_rt;
`endif
      stall = $urandom_range(0, 2);
      for (int k = 0; k <= stall; k++) begin
        rsp_ready = (k == stall);
        rand_wb(rs, rt); #1;
        tests++; if (rsp_valid !== 1'b1 || rsp_rs_data !== exp_rs || rsp_rt_data !== exp_rt) begin
          fails++; $display("FAIL rand_rsp[%0d.%0d] got vld=%0b rs=%h rt=%h exp 1/%h/%h", n, k, rsp_valid, rsp_rs_data, rsp_rt_data, exp_rs, exp_rt); end
        tick();
      end
      wb_valid = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = (i < 32 && i != 0) ? $urandom : '0;
    for (int i = 0; i < 32; i++) arch[i] = mem[i];
    test_reset();
    test_basic();
    test_zero();
    test_bypass();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
